axis_upsample2x_stream: RTL and testbench
=========================================

Name: axis_upsample2x_stream

Overview:
- Parametrised AXI-Stream 2x nearest-neighbour upsampler; next generation of the BRAM-buffered upsample wrapper.
- Uses a single line buffer instead of full-frame buffers, so input streams row by row.
- Runtime-configurable square frame side (power of two) and channel count; loops over all channels per start.
- Sits between the DMA MM2S and S2MM streams in the generator datapath.

Parameters:
- DATA_WIDTH, 16, pixel/tdata width in bits.
- MAX_LOG2_W, 6, log2 of maximum frame side (64); line buffer depth = 2**MAX_LOG2_W.
- CH_WIDTH, 9, width of the channel-count config.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset.
- cfg_start  in  1  single-cycle start pulse; sampled only in IDLE.
- cfg_log2_w  in  4  log2 of input side W (0..MAX_LOG2_W); latched on accepted start.
- cfg_num_ch  in  CH_WIDTH  channels per run (>=1); latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final output beat of the final channel.
- err_tlast  out  1  sticky; set on s_axis_tlast mismatch, cleared on accepted start.
- s_axis_tdata  in  DATA_WIDTH  input pixel, raster order.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  expected on the last pixel of each channel.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last beat of each output channel (2W x 2W).
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset: aresetn synchronous, active-low, clock clk. All outputs 0; state IDLE; counters 0.
- Start acceptance: cfg_start is ignored (stays IDLE, busy=0) if cfg_num_ch==0 or cfg_log2_w>MAX_LOG2_W.
- Output mapping: out(r,c) = in(r>>1, c>>1) for r,c in 0..2W-1.
- State IDLE -> RX on accepted start.
- State RX:
  - s_axis_tready=1; each handshake writes line_buf[col] and increments col.
  - After the handshake of pixel col==W-1, go to PREP.
  - s_axis_tready drops in the cycle after that handshake.
- State PREP: exactly 1 cycle; issues line_buf read at address 0.
- State TX:
  - m_axis_tvalid=1 starting 2 cycles after the last row handshake (registered read).
  - Emits 2 output rows of 2W beats. Read address = out_col>>1.
  - tdata/tvalid/tlast held stable while tvalid && !tready. No bubbles while tready=1.
- Row/channel sequencing after the last TX beat:
  - Next input row -> RX.
  - Last row of channel, channel < cfg_num_ch-1 -> RX for next channel; channel counter increments.
  - Last row of last channel -> DONE.
- State DONE: 1 cycle; done=1, busy=0 next cycle; -> IDLE.
- m_axis_tlast = 1 only on beat (2W-1, 2W-1) of each channel.
- s_axis_tlast check: sets err_tlast if tlast=1 on any non-final pixel, or tlast=0 on the channel's final pixel. Data is still accepted; sequencing is unaffected.
- W=1 (cfg_log2_w=0): each channel is 1 input beat in, 4 output beats out; tlast on the 4th.
- Reset asserted mid-run: returns to IDLE next edge; partial data discarded; no done pulse.
- Counters sized from MAX_LOG2_W and CH_WIDTH; no wrap within legal configs.

Optional Feature:
- Macro: UPS_ZERO_INSERT_EN.
- Defined: adds input port cfg_zero_mode (1 bit, latched on start).
  - When 1: out(r,c) = in(r>>1, c>>1) if r and c are both even, else 0.
  - Beat counts, tlast and timing are identical to replicate mode.
- Not defined: port absent; replicate mode only.

Test Plan:
- log2_w=2, num_ch=1, input 0..15, tready=1 -> 64 beats.
  - Rows 0 and 1 are 0,0,1,1,2,2,3,3; rows 6 and 7 are 12,12,13,13,14,14,15,15.
  - tlast only on beat 63; done 1 cycle after beat 63.
- log2_w=1, num_ch=3, input channel k = {4k..4k+3} -> 48 beats, tlast at beats 15/31/47, single done pulse, busy low afterwards.
- Same as scenario 1 with tready random 50% -> identical data sequence; tdata stable during every stall.
- log2_w=0, num_ch=2, inputs 7 and 9 -> output 7,7,7,7,9,9,9,9; tlast at beats 3 and 7.
- tlast early on pixel 5 of a 16-pixel channel -> err_tlast=1, still 64 output beats.
  - Then cfg_start with num_ch=0 -> ignored, busy stays 0.
- aresetn low during TX of channel 1 -> all outputs 0 next cycle.
  - A fresh run afterwards with log2_w=2 produces correct output.

Source files
------------

// File: rtl/axis_upsample2x_stream.sv
// AXI-Stream 2x nearest-neighbour upsampler using a single line buffer, row by row per channel.
// Optional zero-insert mode enabled by defining UPS_ZERO_INSERT_EN.
module axis_upsample2x_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LOG2_W = 6,
    parameter int unsigned CH_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  cfg_start,
    input  logic [3:0]            cfg_log2_w,
    input  logic [CH_WIDTH-1:0]   cfg_num_ch,
`ifdef UPS_ZERO_INSERT_EN
    input  logic                  cfg_zero_mode,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int unsigned CW    = MAX_LOG2_W;
    localparam int unsigned OW    = MAX_LOG2_W + 1;
    localparam int unsigned DEPTH = 2 ** MAX_LOG2_W;
    localparam logic [3:0]  MAX_L2 = 4'(MAX_LOG2_W);

    typedef enum logic [2:0] {StIdle, StRx, StPrep, StTx, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            log2_w_q, log2_w_d;
    logic [CH_WIDTH-1:0]   num_ch_q, num_ch_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [CW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [OW-1:0]         out_col_q, out_col_d;
    logic                  out_odd_q, out_odd_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] line_buf [DEPTH];

    logic [CW-1:0]         w_m1;
    logic [OW-1:0]         ow_m1;
    logic                  last_col, last_row, last_ch, last_out_col;
    logic                  s_hs, m_hs, start_ok;
    logic [OW-1:0]         nxt_out_col;
    logic                  nxt_odd;
    logic [DATA_WIDTH-1:0] beat_data;

    assign w_m1         = CW'((OW'(1) << log2_w_q) - OW'(1));
    assign ow_m1        = {w_m1, 1'b1};
    assign last_col     = (col_q == w_m1);
    assign last_row     = (row_q == w_m1);
    assign last_ch      = (ch_q == num_ch_q - CH_WIDTH'(1));
    assign last_out_col = (out_col_q == ow_m1);
    assign s_hs         = (state_q == StRx) && s_axis_tvalid;
    assign m_hs         = tvalid_q && m_axis_tready;
    assign start_ok     = cfg_start && (cfg_num_ch != '0) && (cfg_log2_w <= MAX_L2);

    // Address of the beat that will be presented after the current one is consumed.
    always_comb begin
        nxt_out_col = out_col_q + OW'(1);
        nxt_odd     = out_odd_q;
        if (state_q == StPrep) begin
            nxt_out_col = '0;
            nxt_odd     = 1'b0;
        end else if (last_out_col) begin
            nxt_out_col = '0;
            nxt_odd     = ~out_odd_q;
        end
    end

`ifdef UPS_ZERO_INSERT_EN
    logic zero_q, zero_d;
    assign beat_data = (zero_q && (nxt_odd || nxt_out_col[0])) ? '0
                                                              : line_buf[nxt_out_col[OW-1:1]];
`else
    assign beat_data = line_buf[nxt_out_col[OW-1:1]];
`endif

    always_comb begin
        state_d   = state_q;
        log2_w_d  = log2_w_q;
        num_ch_d  = num_ch_q;
        ch_d      = ch_q;
        row_d     = row_q;
        col_d     = col_q;
        out_col_d = out_col_q;
        out_odd_d = out_odd_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        err_d     = err_q;
`ifdef UPS_ZERO_INSERT_EN
        zero_d    = zero_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    log2_w_d = cfg_log2_w;
                    num_ch_d = cfg_num_ch;
                    ch_d     = '0;
                    row_d    = '0;
                    col_d    = '0;
                    err_d    = 1'b0;
`ifdef UPS_ZERO_INSERT_EN
                    zero_d   = cfg_zero_mode;
`endif
                    state_d  = StRx;
                end
            end
            StRx: begin
                if (s_hs) begin
                    col_d = col_q + CW'(1);
                    if (s_axis_tlast != (last_row && last_col)) err_d = 1'b1;
                    if (last_col) begin
                        col_d   = '0;
                        state_d = StPrep;
                    end
                end
            end
            StPrep: begin
                out_col_d = nxt_out_col;
                out_odd_d = nxt_odd;
                tdata_d   = beat_data;
                tvalid_d  = 1'b1;
                state_d   = StTx;
            end
            StTx: begin
                if (m_hs) begin
                    if (last_out_col && out_odd_q) begin
                        // Both output rows of this input row are out.
                        out_col_d = '0;
                        out_odd_d = 1'b0;
                        tvalid_d  = 1'b0;
                        tdata_d   = '0;
                        if (!last_row) begin
                            row_d   = row_q + CW'(1);
                            state_d = StRx;
                        end else if (!last_ch) begin
                            row_d   = '0;
                            ch_d    = ch_q + CH_WIDTH'(1);
                            state_d = StRx;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        out_col_d = nxt_out_col;
                        out_odd_d = nxt_odd;
                        tdata_d   = beat_data;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            log2_w_q  <= '0;
            num_ch_q  <= '0;
            ch_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_col_q <= '0;
            out_odd_q <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef UPS_ZERO_INSERT_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            log2_w_q  <= log2_w_d;
            num_ch_q  <= num_ch_d;
            ch_q      <= ch_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_col_q <= out_col_d;
            out_odd_q <= out_odd_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            err_q     <= err_d;
`ifdef UPS_ZERO_INSERT_EN
            zero_q    <= zero_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (s_hs) line_buf[col_q] <= s_axis_tdata;
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign err_tlast     = err_q;
    assign s_axis_tready = (state_q == StRx);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q && out_odd_q && last_out_col && last_row;

endmodule

// File: tb/tb_axis_upsample2x_stream.sv
// Directed self-checking bench for axis_upsample2x_stream (replicate mode).
module tb_axis_upsample2x_stream;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [3:0]  cfg_log2_w = '0;
    logic [8:0]  cfg_num_ch = '0;
`ifdef UPS_ZERO_INSERT_EN
    logic        cfg_zero_mode = 1'b0;
`endif
    logic        busy, done, err_tlast;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b1;

    axis_upsample2x_stream dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .cfg_start     (cfg_start),
        .cfg_log2_w    (cfg_log2_w),
        .cfg_num_ch    (cfg_num_ch),
`ifdef UPS_ZERO_INSERT_EN
        .cfg_zero_mode (cfg_zero_mode),
`endif
        .busy          (busy),
        .done          (done),
        .err_tlast     (err_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          stall_bad = 0;
    logic        done_after = 1'b0;
    bit          abort_in = 1'b0;
    logic [15:0] in_q[$];
    logic        in_last[$];
    logic [15:0] got_data[$];
    logic        got_last[$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic start(input logic [3:0] l2, input logic [8:0] nch);
        @(negedge clk);
        cfg_log2_w = l2;
        cfg_num_ch = nch;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    // Inputs change and handshakes are judged on the falling edge.
    task automatic drive_in(input int budget);
        int i = 0;
        int cyc = 0;
        while (i < in_q.size() && cyc < budget && !abort_in) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = in_q[i];
            s_axis_tlast  = in_last[i];
            if (s_axis_tready) i++;
            @(negedge clk);
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic collect(input int n, input bit rnd, input logic final_ready, input int budget);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [15:0] hold = '0;
        logic        hold_last = 1'b0;
        got_data.delete();
        got_last.delete();
        stall_bad = 0;
        while (got_data.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold
                            || m_axis_tlast !== hold_last)) stall_bad++;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = m_axis_tvalid && !m_axis_tready;
            hold      = m_axis_tdata;
            hold_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
            end
        end
        @(negedge clk);
        done_after    = done;
        m_axis_tready = final_ready;
    endtask

    task automatic load_ramp(input int nch, input int npix, input int bad_last_at);
        in_q.delete();
        in_last.delete();
        for (int i = 0; i < nch * npix; i++) begin
            in_q.push_back(16'(i));
            in_last.push_back((i == bad_last_at) ? 1'b1 : ((i % npix) == npix - 1));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err_tlast !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_tlast); end
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_sready: got %b want 0", s_axis_tready); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_mvalid: got %b want 0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 16'h0) begin bad++; $display("FAIL reset_mdata: got %0d want 0", m_axis_tdata); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_mlast: got %b want 0", m_axis_tlast); end
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    // W=4, one channel: out(r,c) = in[(r/2)*4 + c/2].
    task automatic check_w4(input string tag);
        logic [15:0] row0 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        logic [15:0] row7 [8] = '{12, 12, 13, 13, 14, 14, 15, 15};
        int lasts = 0;
        total++;
        if (got_data.size() != 64) begin
            bad++; $display("FAIL %s_count: got %0d want 64", tag, got_data.size());
        end
        for (int k = 0; k < got_data.size(); k++) begin
            total++;
            if (got_data[k] !== 16'(((k / 8) >> 1) * 4 + ((k % 8) >> 1))) begin
                bad++; $display("FAIL %s_beat%0d: got %0d want %0d", tag, k, got_data[k],
                                ((k / 8) >> 1) * 4 + ((k % 8) >> 1));
            end
            if (got_last[k]) lasts++;
        end
        for (int c = 0; c < 8; c++) begin
            total++;
            if (got_data[c] !== row0[c] || got_data[8 + c] !== row0[c]
                || got_data[48 + c] !== row7[c] || got_data[56 + c] !== row7[c]) begin
                bad++; $display("FAIL %s_rows_col%0d: got %0d/%0d/%0d/%0d want %0d/%0d", tag, c,
                                got_data[c], got_data[8 + c], got_data[48 + c], got_data[56 + c],
                                row0[c], row7[c]);
            end
        end
        total++;
        if (lasts != 1 || got_last[63] !== 1'b1) begin
            bad++; $display("FAIL %s_tlast: got count %0d last63 %b want 1 1", tag, lasts, got_last[63]);
        end
    endtask

    task automatic test_replicate();
        int d0 = done_cnt;
        load_ramp(1, 16, -1);
        start(4'd2, 9'd1);
        fork
            drive_in(4000);
            collect(64, 1'b0, 1'b1, 4000);
        join
        check_w4("basic");
        total++; if (done_after !== 1'b1) begin bad++; $display("FAIL basic_done_timing: got %b want 1", done_after); end
        @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        total++; if (err_tlast !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_tlast); end
    endtask

    task automatic test_multi_channel();
        int d0 = done_cnt;
        int exp;
        load_ramp(3, 4, -1);
        start(4'd1, 9'd3);
        fork
            drive_in(4000);
            collect(48, 1'b0, 1'b1, 4000);
        join
        total++;
        if (got_data.size() != 48) begin bad++; $display("FAIL multi_count: got %0d want 48", got_data.size()); end
        for (int k = 0; k < got_data.size(); k++) begin
            exp = 4 * (k / 16) + (((k % 16) / 4) >> 1) * 2 + (((k % 16) % 4) >> 1);
            total++;
            if (got_data[k] !== 16'(exp) || got_last[k] !== ((k % 16) == 15)) begin
                bad++; $display("FAIL multi_beat%0d: got %0d/%b want %0d/%b", k, got_data[k],
                                got_last[k], exp, (k % 16) == 15);
            end
        end
        repeat (2) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL multi_done_cnt: got %0d want 1", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multi_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        load_ramp(1, 16, -1);
        start(4'd2, 9'd1);
        fork
            drive_in(4000);
            collect(64, 1'b1, 1'b1, 4000);
        join
        m_axis_tready = 1'b1;
        check_w4("stall");
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_stable: got %0d want 0", stall_bad); end
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        logic [15:0] exp [8] = '{7, 7, 7, 7, 9, 9, 9, 9};
        in_q = '{16'd7, 16'd9};
        in_last = '{1'b1, 1'b1};
        start(4'd0, 9'd2);
        fork
            drive_in(4000);
            collect(8, 1'b0, 1'b1, 4000);
        join
        total++;
        if (got_data.size() != 8) begin bad++; $display("FAIL w1_count: got %0d want 8", got_data.size()); end
        for (int k = 0; k < got_data.size(); k++) begin
            total++;
            if (got_data[k] !== exp[k] || got_last[k] !== (k == 3 || k == 7)) begin
                bad++; $display("FAIL w1_beat%0d: got %0d/%b want %0d/%b", k, got_data[k],
                                got_last[k], exp[k], (k == 3 || k == 7));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_tlast_error();
        load_ramp(1, 16, 5);
        start(4'd2, 9'd1);
        fork
            drive_in(4000);
            collect(64, 1'b0, 1'b1, 4000);
        join
        check_w4("tlast_err");
        total++; if (err_tlast !== 1'b1) begin bad++; $display("FAIL tlast_err_flag: got %b want 1", err_tlast); end
        @(negedge clk);
        start(4'd2, 9'd0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nch0_ignored: got busy %b want 0", busy); end
        start(4'd7, 9'd1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL log2w7_ignored: got busy %b want 0", busy); end
        total++; if (err_tlast !== 1'b1) begin bad++; $display("FAIL err_kept: got %b want 1", err_tlast); end
    endtask

    task automatic test_reset_mid_run();
        int d0;
        logic [15:0] exp [4] = '{4, 4, 5, 5};
        load_ramp(2, 4, -1);
        start(4'd1, 9'd2);
        fork
            drive_in(4000);
        join_none
        collect(20, 1'b0, 1'b0, 4000);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_data[16 + k] !== exp[k]) begin
                bad++; $display("FAIL mid_ch1_beat%0d: got %0d want %0d", k, got_data[16 + k], exp[k]);
            end
        end
        d0 = done_cnt;
        aresetn = 1'b0;
        abort_in = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, err_tlast, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 6'b0
            || m_axis_tdata !== 16'h0) begin
            bad++; $display("FAIL mid_reset_outputs: got %b data %0d want 0",
                            {busy, done, err_tlast, s_axis_tready, m_axis_tvalid, m_axis_tlast},
                            m_axis_tdata);
        end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        abort_in = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); end
        load_ramp(1, 16, -1);
        start(4'd2, 9'd1);
        fork
            drive_in(4000);
            collect(64, 1'b0, 1'b1, 4000);
        join
        check_w4("after_reset");
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_replicate();
        test_multi_channel();
        test_backpressure();
        test_single_pixel();
        test_tlast_error();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
